// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, flush-to-bubble and an optional
// two-entry skid buffer; counts valid beats killed by flush.
module pipe_stage_reg #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 139,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              flush,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

    state_t            state_p1, state_nxt;
    logic [CTRL_W-1:0] ctrl_p1, skid_ctrl_p1;
    logic [DATA_W-1:0] data_p1, skid_data_p1;
    logic [CNT_W-1:0]  cnt_p1;
    logic              accept, emit;
    logic              load_in, load_skid, load_from_skid, clr_main;
    logic [1:0]        held, kill_cnt;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign valid_out = (state_p1 != ST_EMPTY);

    // With the skid buffer, ready depends only on registered state, never on ready_in.
    generate
        if (SKID != 0) begin : g_skid_ready
            assign ready_out = ~rst & (state_p1 != ST_SKID);
        end else begin : g_comb_ready
            assign ready_out = ~rst & (ready_in | ~valid_out);
        end
    endgenerate

    assign accept = valid_in & ready_out;
    assign emit   = valid_out & ready_in;

    always_comb begin
        state_nxt      = state_p1;
        load_in        = 1'b0;
        load_skid      = 1'b0;
        load_from_skid = 1'b0;
        clr_main       = 1'b0;
        held           = 2'd0;
        case (state_p1)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_FULL;
                    load_in   = 1'b1;
                end
            end
            ST_FULL: begin
                held = 2'd1;
                if (accept && emit) begin
                    load_in = 1'b1;
                end else if (accept) begin
                    state_nxt = ST_SKID;
                    load_skid = 1'b1;
                end else if (emit) begin
                    state_nxt = ST_EMPTY;
                    clr_main  = 1'b1;
                end
            end
            ST_SKID: begin
                held = 2'd2;
                if (emit) begin
                    state_nxt      = ST_FULL;
                    load_from_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // Flush overrides any transfer; a beat emitted on this edge was delivered.
        if (flush) begin
            state_nxt      = ST_EMPTY;
            load_in        = 1'b0;
            load_skid      = 1'b0;
            load_from_skid = 1'b0;
            clr_main       = 1'b1;
        end
    end

    assign kill_cnt = held - {1'b0, emit} + {1'b0, accept};

    // Stage p1: control state and flush counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= ST_EMPTY;
            cnt_p1   <= '0;
        end else begin
            state_p1 <= state_nxt;
            if (flush) begin
                cnt_p1 <= sat_add(cnt_p1, kill_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_p1 <= '0;
            data_p1 <= '0;
        end else if (load_in) begin
            ctrl_p1 <= ctrl_in;
            data_p1 <= data_in;
        end else if (load_from_skid) begin
            ctrl_p1 <= skid_ctrl_p1;
            data_p1 <= skid_data_p1;
        end else if (clr_main) begin
            ctrl_p1 <= '0;
        end
    end

    // Skid entry is only read when its state says it is valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_ctrl_p1 <= ctrl_in;
            skid_data_p1 <= data_in;
        end
    end

    assign ctrl_out  = ctrl_p1;
    assign data_out  = data_p1;
    assign flush_cnt = cnt_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid instance (CNT_W=2) and a plain-register
// instance (SKID=0) driven by the same stimulus.
module tb_pipe_stage_reg;

    localparam int CTRL_W = 16;
    localparam int DATA_W = 139;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic [DATA_W-1:0] data_in;
    logic              ready_in;
    logic              flush;

    logic              ready_out_s, valid_out_s;
    logic [CTRL_W-1:0] ctrl_out_s;
    logic [DATA_W-1:0] data_out_s;
    logic [1:0]        flush_cnt_s;

    logic              ready_out_r, valid_out_r;
    logic [CTRL_W-1:0] ctrl_out_r;
    logic [DATA_W-1:0] data_out_r;
    logic [15:0]       flush_cnt_r;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out_s),
        .ctrl_in(ctrl_in), .data_in(data_in), .valid_out(valid_out_s),
        .ready_in(ready_in), .ctrl_out(ctrl_out_s), .data_out(data_out_s),
        .flush(flush), .flush_cnt(flush_cnt_s)
    );

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out_r),
        .ctrl_in(ctrl_in), .data_in(data_in), .valid_out(valid_out_r),
        .ready_in(ready_in), .ctrl_out(ctrl_out_r), .data_out(data_out_r),
        .flush(flush), .flush_cnt(flush_cnt_r)
    );

    function automatic logic [CTRL_W-1:0] bc(input int k);
        return CTRL_W'(32'h20 + k);
    endfunction

    function automatic logic [DATA_W-1:0] bd(input int k);
        return DATA_W'(32'h100 + k);
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; bubbles must carry an all-zero control field.
    task automatic tick();
        @(posedge clk);
        #2;
        if (valid_out_s === 1'b0) chk("inv_ctrl_s", 160'(ctrl_out_s), 160'(0));
        if (valid_out_r === 1'b0) chk("inv_ctrl_r", 160'(ctrl_out_r), 160'(0));
    endtask

    task automatic drive(input logic vin, input int k, input logic rin, input logic fl);
        valid_in = vin;
        ctrl_in  = bc(k);
        data_in  = bd(k);
        ready_in = rin;
        flush    = fl;
    endtask

    task automatic row(input string tag, input logic vin, input int k, input logic rin,
                       input logic exp_rdy, input logic exp_v, input int ek);
        drive(vin, k, rin, 1'b0);
        #1;
        chk({tag, "_rdy"}, 160'(ready_out_s), 160'(exp_rdy));
        chk({tag, "_vld"}, 160'(valid_out_s), 160'(exp_v));
        if (exp_v) begin
            chk({tag, "_ctrl"}, 160'(ctrl_out_s), 160'(bc(ek)));
            chk({tag, "_data"}, 160'(data_out_s), 160'(bd(ek)));
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 0, 1'b1, 1'b0);
        tick();
        tick();
        chk("rst_rdy_s", 160'(ready_out_s), 160'(0));
        chk("rst_rdy_r", 160'(ready_out_r), 160'(0));
        chk("rst_vld_s", 160'(valid_out_s), 160'(0));
        chk("rst_vld_r", 160'(valid_out_r), 160'(0));
        chk("rst_ctrl_s", 160'(ctrl_out_s), 160'(0));
        chk("rst_data_s", 160'(data_out_s), 160'(0));
        chk("rst_cnt_s", 160'(flush_cnt_s), 160'(0));
        chk("rst_cnt_r", 160'(flush_cnt_r), 160'(0));

        // First beat after reset
        rst      = 1'b0;
        valid_in = 1'b1;
        ctrl_in  = 16'h00A5;
        data_in  = DATA_W'(1);
        ready_in = 1'b1;
        #1;
        chk("c1_rdy_s", 160'(ready_out_s), 160'(1));
        chk("c1_rdy_r", 160'(ready_out_r), 160'(1));
        tick();
        chk("c1_vld_s", 160'(valid_out_s), 160'(1));
        chk("c1_vld_r", 160'(valid_out_r), 160'(1));
        chk("c1_ctrl_s", 160'(ctrl_out_s), 160'(16'h00A5));
        chk("c1_ctrl_r", 160'(ctrl_out_r), 160'(16'h00A5));
        chk("c1_data_s", 160'(data_out_s), 160'(1));
        valid_in = 1'b0;
        tick();
        chk("c1_drain_s", 160'(valid_out_s), 160'(0));
        chk("c1_hold_data_s", 160'(data_out_s), 160'(1));

        // Back-to-back stream, one beat per cycle
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, i, 1'b1, 1'b0);
            tick();
            chk("c2_vld_s", 160'(valid_out_s), 160'(1));
            chk("c2_ctrl_s", 160'(ctrl_out_s), 160'(bc(i)));
            chk("c2_data_s", 160'(data_out_s), 160'(bd(i)));
            chk("c2_ctrl_r", 160'(ctrl_out_r), 160'(bc(i)));
        end
        drive(1'b0, 0, 1'b1, 1'b0);
        tick();
        chk("c2_end_s", 160'(valid_out_s), 160'(0));
        chk("c2_end_r", 160'(valid_out_r), 160'(0));

        // Stall cycles 2..4 against the skid instance
        row("c3_0", 1'b1, 0, 1'b1, 1'b1, 1'b0, 0);
        row("c3_1", 1'b1, 1, 1'b1, 1'b1, 1'b1, 0);
        row("c3_2", 1'b1, 2, 1'b0, 1'b1, 1'b1, 1);
        row("c3_3", 1'b1, 3, 1'b0, 1'b0, 1'b1, 1);
        row("c3_4", 1'b1, 3, 1'b0, 1'b0, 1'b1, 1);
        row("c3_5", 1'b1, 3, 1'b1, 1'b0, 1'b1, 1);
        row("c3_6", 1'b1, 3, 1'b1, 1'b1, 1'b1, 2);
        row("c3_7", 1'b1, 4, 1'b1, 1'b1, 1'b1, 3);
        row("c3_8", 1'b1, 5, 1'b1, 1'b1, 1'b1, 4);
        row("c3_9", 1'b0, 0, 1'b1, 1'b1, 1'b1, 5);
        row("c3_a", 1'b0, 0, 1'b1, 1'b1, 1'b0, 0);

        // Fill the skid, then flush both held beats
        rst = 1'b1;
        drive(1'b0, 0, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b1, 6, 1'b0, 1'b0);
        tick();
        drive(1'b1, 7, 1'b0, 1'b0);
        #1;
        chk("c4_rdy_s", 160'(ready_out_s), 160'(1));
        chk("c4_rdy_r", 160'(ready_out_r), 160'(0));
        tick();
        chk("c4_full_rdy_s", 160'(ready_out_s), 160'(0));
        chk("c4_full_ctrl_s", 160'(ctrl_out_s), 160'(bc(6)));
        drive(1'b0, 0, 1'b0, 1'b1);
        tick();
        chk("c4_vld_s", 160'(valid_out_s), 160'(0));
        chk("c4_ctrl_s", 160'(ctrl_out_s), 160'(0));
        chk("c4_data_s", 160'(data_out_s), 160'(bd(6)));
        chk("c4_cnt_s", 160'(flush_cnt_s), 160'(2));
        chk("c4_rdy_after_s", 160'(ready_out_s), 160'(1));
        chk("c4_vld_r", 160'(valid_out_r), 160'(0));
        chk("c4_cnt_r", 160'(flush_cnt_r), 160'(1));

        // Flush kills the incoming beat; the 2-bit counter saturates
        rst = 1'b1;
        drive(1'b0, 0, 1'b1, 1'b0);
        tick();
        chk("c5_rst_cnt_s", 160'(flush_cnt_s), 160'(0));
        rst = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            drive(1'b1, 8, 1'b1, 1'b1);
            #1;
            chk("c5_rdy_s", 160'(ready_out_s), 160'(1));
            tick();
            chk("c5_vld_s", 160'(valid_out_s), 160'(0));
            chk("c5_vld_r", 160'(valid_out_r), 160'(0));
            chk("c5_cnt_s", 160'(flush_cnt_s), 160'((n > 3) ? 3 : n));
            chk("c5_cnt_r", 160'(flush_cnt_r), 160'(n));
        end
        drive(1'b0, 0, 1'b1, 1'b1);
        tick();
        chk("c6_idle_cnt_s", 160'(flush_cnt_s), 160'(3));
        chk("c6_idle_cnt_r", 160'(flush_cnt_r), 160'(5));
        rst = 1'b1;
        drive(1'b0, 0, 1'b1, 1'b0);
        tick();
        chk("c6_rst_cnt_s", 160'(flush_cnt_s), 160'(0));
        chk("c6_rst_cnt_r", 160'(flush_cnt_r), 160'(0));
        rst = 1'b0;

        // A beat emitted on the flush edge is delivered, not killed
        drive(1'b1, 9, 1'b0, 1'b0);
        tick();
        chk("c7_vld_s", 160'(valid_out_s), 160'(1));
        chk("c7_vld_r", 160'(valid_out_r), 160'(1));
        drive(1'b1, 10, 1'b1, 1'b1);
        tick();
        chk("c7_cnt_s", 160'(flush_cnt_s), 160'(1));
        chk("c7_cnt_r", 160'(flush_cnt_r), 160'(1));
        chk("c7_vld_after_s", 160'(valid_out_s), 160'(0));
        chk("c7_vld_after_r", 160'(valid_out_r), 160'(0));
        drive(1'b1, 11, 1'b0, 1'b0);
        tick();
        drive(1'b0, 0, 1'b0, 1'b1);
        tick();
        chk("c7_held_cnt_s", 160'(flush_cnt_s), 160'(2));
        chk("c7_held_cnt_r", 160'(flush_cnt_r), 160'(2));

        // Reset while beats are held
        drive(1'b1, 12, 1'b0, 1'b0);
        tick();
        drive(1'b1, 13, 1'b0, 1'b0);
        tick();
        chk("c8_skid_rdy_s", 160'(ready_out_s), 160'(0));
        rst = 1'b1;
        drive(1'b0, 0, 1'b1, 1'b0);
        #1;
        chk("c8_rst_rdy_r", 160'(ready_out_r), 160'(0));
        tick();
        chk("c8_vld_s", 160'(valid_out_s), 160'(0));
        chk("c8_vld_r", 160'(valid_out_r), 160'(0));
        chk("c8_ctrl_s", 160'(ctrl_out_s), 160'(0));
        chk("c8_cnt_s", 160'(flush_cnt_s), 160'(0));
        chk("c8_cnt_r", 160'(flush_cnt_r), 160'(0));
        rst = 1'b0;
        tick();
        chk("c8_post_vld_s", 160'(valid_out_s), 160'(0));
        chk("c8_post_vld_r", 160'(valid_out_r), 160'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
